// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared state encoding, sizes and one-hot helper for the mux select arbiter.
package mux_sel_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int N_SRC = 4;
  localparam int SEL_W = 2;
  function automatic logic [N_SRC-1:0] onehot4(input logic [SEL_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: round-robin search over four requests starting just after the last-grant pointer.
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] k_o,
  output logic             found_o
);
  // Scan farthest-first so the nearest asserted request overwrites and wins.
  always_comb begin
    k_o = '0;
    for (int i = N_SRC; i >= 1; i--)
      if (req_i[ptr_i + SEL_W'(i)]) k_o = ptr_i + SEL_W'(i);
  end
  assign found_o = |req_i;
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving the 4-to-1 mux select, with dwell-limited grants
// and a one-cycle done pulse when each grant ends.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   req_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               release_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic [N_SRC-1:0]   gnt_o,
  output logic               busy_o,
  output logic               done_o
);
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d, sel_q, sel_d, k;
  logic [N_SRC-1:0]   gnt_q, gnt_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d, found, fin;

  rr_pick4 u_pick (.req_i(req_i), .ptr_i(ptr_q), .k_o(k), .found_o(found));

  assign fin = cnt_q == DWELL_W'(1) || release_i || !req_i[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = GRANT;
        ptr_d   = k;
        sel_d   = k;
        gnt_d   = onehot4(k);
        cnt_d   = dwell_i == '0 ? DWELL_W'(1) : dwell_i;
      end
    end else begin
      cnt_d = cnt_q - DWELL_W'(1);
      if (fin) begin
        state_d = IDLE;
        gnt_d   = '0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(N_SRC - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sel_o  = sel_q;
  assign gnt_o  = gnt_q;
  assign busy_o = |gnt_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed cycle-by-cycle vectors plus a round-robin fairness sequence.
module tb_mux_sel_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0, release_i = 1'b0;
  logic [3:0] req_i = '0, dwell_i = '0, gnt_o;
  logic [1:0] sel_o;
  logic       busy_o, done_o;
  int         n_vec = 0, n_err = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] dwell;
    logic       rel;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t tbl[$];

  mux_sel_arbiter #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .dwell_i(dwell_i), .release_i(release_i),
    .sel_o(sel_o), .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic v(input logic r, input logic [3:0] q, input logic [3:0] d, input logic l,
                   input logic [1:0] s, input logic [3:0] g, input logic b, input logic dn);
    tbl.push_back('{r, q, d, l, s, g, b, dn});
  endtask

  task automatic step_chk(input string name, input logic r, input logic [3:0] q,
                          input logic [3:0] d, input logic l, input logic [1:0] s,
                          input logic [3:0] g, input logic b, input logic dn);
    rst_n = r; req_i = q; dwell_i = d; release_i = l;
    @(posedge clk);
    #1;
    n_vec++;
    if ({sel_o, gnt_o, busy_o, done_o} !== {s, g, b, dn}) begin
      n_err++;
      $display("FAIL %s: got sel=%0d gnt=%b busy=%b done=%b, want sel=%0d gnt=%b busy=%b done=%b",
               name, sel_o, gnt_o, busy_o, done_o, s, g, b, dn);
    end
  endtask

  initial begin
    // reset, first pick of input 0 with dwell 3
    v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    v(1, 4'b0001, 3, 0, 0, 4'b0001, 1, 0);
    v(1, 4'b0001, 3, 0, 0, 4'b0001, 1, 0);
    v(1, 4'b0001, 3, 0, 0, 4'b0001, 1, 0);
    v(1, 4'b0001, 3, 0, 0, 4'b0000, 0, 1);
    v(1, 4'b0000, 3, 0, 0, 4'b0000, 0, 0);
    // release on the 3rd cycle of a grant to input 2
    v(1, 4'b0100, 10, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0100, 10, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0100, 10, 1, 2, 4'b0000, 0, 1);
    v(1, 4'b0000, 10, 0, 2, 4'b0000, 0, 0);
    // req[2] dropped on the 4th cycle of a second grant
    v(1, 4'b0100, 10, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0100, 10, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0100, 10, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0000, 10, 0, 2, 4'b0000, 0, 1);
    v(1, 4'b0000, 10, 0, 2, 4'b0000, 0, 0);
    // dwell 0 gives a single-cycle grant
    v(1, 4'b0010, 0, 0, 1, 4'b0010, 1, 0);
    v(1, 4'b0010, 0, 0, 1, 4'b0000, 0, 1);
    v(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    // dwell 2 with release on the final cycle: one done pulse
    v(1, 4'b0001, 2, 0, 0, 4'b0001, 1, 0);
    v(1, 4'b0001, 2, 0, 0, 4'b0001, 1, 0);
    v(1, 4'b0001, 2, 1, 0, 4'b0000, 0, 1);
    v(1, 4'b0000, 2, 0, 0, 4'b0000, 0, 0);
    // reset mid-grant to input 3, then input 3 granted again from the reset pointer
    v(1, 4'b1000, 5, 0, 3, 4'b1000, 1, 0);
    v(1, 4'b1000, 5, 0, 3, 4'b1000, 1, 0);
    v(0, 4'b1000, 5, 0, 0, 4'b0000, 0, 0);
    v(1, 4'b1000, 2, 0, 3, 4'b1000, 1, 0);
    v(1, 4'b1000, 2, 0, 3, 4'b1000, 1, 0);
    v(1, 4'b1000, 2, 0, 3, 4'b0000, 0, 1);
    v(1, 4'b0000, 2, 0, 3, 4'b0000, 0, 0);
    // other requests and dwell churn during a grant to input 2
    v(1, 4'b0100, 4, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b1111, 1, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0101, 0, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b1110, 15, 0, 2, 4'b0100, 1, 0);
    v(1, 4'b0100, 7, 0, 2, 4'b0000, 0, 1);
    v(1, 4'b0000, 7, 0, 2, 4'b0000, 0, 0);
    // release while idle is ignored
    v(1, 4'b0000, 7, 1, 2, 4'b0000, 0, 0);
    v(1, 4'b0000, 7, 0, 2, 4'b0000, 0, 0);

    foreach (tbl[i])
      step_chk($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].dwell, tbl[i].rel,
               tbl[i].sel, tbl[i].gnt, tbl[i].busy, tbl[i].done);

    // fairness: all requesting, dwell 2, order 0,1,2,3,0 after reset
    step_chk("rr_reset", 0, 4'b1111, 2, 0, 0, 4'b0000, 0, 0);
    for (int g = 0; g < 5; g++) begin
      logic [1:0] s;
      s = 2'(g);
      step_chk($sformatf("rr%0d_c0", g), 1, 4'b1111, 2, 0, s, 4'b0001 << s, 1, 0);
      step_chk($sformatf("rr%0d_c1", g), 1, 4'b1111, 2, 0, s, 4'b0001 << s, 1, 0);
      step_chk($sformatf("rr%0d_done", g), 1, 4'b1111, 2, 0, s, 4'b0000, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 4-to-1 data mux. It decides which of four sources the mux routes and drives the mux's 2-bit `sel`. It also drives a one-hot grant back to the requesters, holds each grant for a programmable dwell, and pulses `done` when a grant ends. The mux itself stays purely combinational; all sequencing lives here.

Parameters:
- DWELL_W, 4, width of the dwell-count input; maximum grant length is 2^DWELL_W-1 cycles.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  4  request per mux input; req[i] asks for mux input i.
- dwell  input  DWELL_W  grant length in cycles; sampled only when a grant is issued.
- release  input  1  requests early termination of the current grant.
- sel  output  2  mux select, registered; index of the current or most recent grant.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- busy  output  1  high while a grant is active (equals |gnt).
- done  output  1  one-cycle pulse on the cycle after a grant ends.

Behaviour:
- Reset: synchronous and active-low. With rst_n=0 at a rising edge, the next state is:
  - sel=2'd0, gnt=4'b0000, busy=0, done=0
  - internal last-grant pointer = 3, so req[0] has first priority
  - dwell counter = 0, state = IDLE
- Reset mid-grant aborts the grant at that edge; no done pulse is generated.
- States:
  - IDLE: no grant active. If req != 0 at an edge, the next state is GRANT. Otherwise stay in IDLE.
  - GRANT: exactly one gnt bit is high.
- Arbitration, evaluated in IDLE only:
  - Search order is ptr+1, ptr+2, ptr+3, ptr+4, all modulo 4.
  - The first asserted req wins; call it k.
  - At the edge: sel<=k, gnt<=one-hot(k), busy<=1, ptr<=k.
  - cnt <= (dwell==0) ? 1 : dwell.
- Latency: req sampled high at edge t (while IDLE) gives gnt/sel valid after edge t.
- GRANT, at each edge:
  - cnt decrements.
  - The grant ends when any of these holds: cnt==1, release==1, or req[sel]==0.
  - On end: gnt<=0, busy<=0, done<=1, next state IDLE.
  - Otherwise: hold gnt/sel, done<=0.
- Grant length with no early end is max(dwell,1) cycles of gnt high.
- Several end conditions in the same cycle produce a single done pulse.
- done is high for exactly one cycle. During that cycle the state is IDLE, and arbitration may issue a new grant at the same edge that clears done. Minimum gap between grants: 1 cycle with gnt=0.
- sel holds its last granted value while IDLE. It never glitches and changes only at grant issue.
- Changes to req of non-granted inputs during GRANT have no effect until IDLE.
- dwell changes during GRANT have no effect on the current grant.
- release while IDLE is ignored.
- Counter width is DWELL_W. Decrement never underflows, because the grant ends at cnt==1.

Decomposition:
- Shared package mux_sel_pkg holds:
  - state encoding: IDLE=1'b0, GRANT=1'b1
  - N_SRC=4 and SEL_W=2
  - function onehot4(sel) returning the 4-bit one-hot of a 2-bit index
- One natural sub-module, rr_pick4: combinational priority search taking req and ptr, returning k and a found flag. Everything else stays in the top.

Test Plan:
- Reset and first pick: hold rst_n=0 for 2 cycles, then req=4'b0001 with dwell=3. Required: after reset gnt=0, sel=0, busy=0. Then gnt=0001 and sel=0 for exactly 3 cycles, then done=1 for 1 cycle with gnt=0.
- Round-robin fairness: req=4'b1111 held, dwell=2. Required grant order is sel 0,1,2,3,0, each 2 cycles, with one idle/done cycle between grants.
- Early termination: grant to input 2 with dwell=10. Assert release on the 3rd grant cycle; separately, drop req[2] on the 4th cycle of a second grant. Required: gnt clears at the next edge each time, with a single done pulse and ptr=2.
- dwell=0 and simultaneous end: dwell=0 gives a 1-cycle grant. With dwell=2 and release asserted on the final cycle, the bench sees exactly one done pulse.
- Reset mid-grant: rst_n=0 during an active grant to input 3. Required: next edge gnt=0, sel=0, done=0. The next req=4'b1000 is granted, since the pointer reset to 3 and the search wraps to 3 last but finds only 3.
- Stability: while gnt=0100, toggle req[0], req[1], req[3] and change dwell. Required: sel stays 2 and the grant length is unchanged.
